display_scan_ctrl: RTL and testbench

Time-multiplexed scan scheduler that shares one seg7 decoder and one segment bus between NUM_DIGITS common-cathode digits. Holds a double-buffered BCD frame: the active buffer is scanned, and the pending buffer is loaded through a valid/ready handshake. Inserts blanking dead-time between digit slots to prevent ghosting. Sits between the digit counters and the seg7 decoder / digit-enable pins.

---
 rtl/display_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// display_scan_ctrl
// ----------------------------------------------------------------------------
// Time-multiplexed scan scheduler for NUM_DIGITS common-cathode digits that
// share one seg7 decoder and one segment bus. The active BCD frame is scanned
// digit 0 first. Each digit slot has BLANK_CYCLES of dead-time followed by
// SCAN_DIV cycles of drive. A second (pending) frame buffer is loaded through
// a valid/ready handshake. It is copied into the active buffer only while
// idle or at a frame boundary, so a frame is never shown half old, half new.
//
// Configuration macro:
//   LZ_SUPPRESS_EN - when defined, leading-zero digits (digit i>0 whose value
//                    and all higher digits are 0) are kept dark during their
//                    drive slot. Slot timing and frame_done are unaffected.
//
// Parameters:
//   NUM_DIGITS   - scanned digits, 1..8
//   SCAN_DIV     - clk cycles a digit is driven per slot, >= 1
//   BLANK_CYCLES - dead-time cycles before each slot, >= 0 (0 = no blanking)
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   enable     in   scan enable, sampled every cycle
//   load_valid in   new frame offered on load_data
//   load_ready out  pending buffer empty; a valid frame is taken this cycle
//   load_data  in   BCD frame, digit i = load_data[4i+3:4i]
//   bcd_out    out  nibble to the shared seg7 decoder
//   digit_sel  out  one-hot digit enable, active-high
//   blank      out  1 = segment drivers off
//   frame_done out  one-cycle pulse after the last digit slot of a frame
// ============================================================================
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 250,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    blank,
    output logic                    frame_done
);

    localparam int FW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int SW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    // One slot counter serves both phases, so it is as wide as the longer one.
    localparam int CW = (SW > BW) ? SW : BW;

    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Every slot starts with dead-time unless dead-time is configured away.
    localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [IW-1:0]         r_index;
    logic [CW-1:0]         r_count;
    logic [FW-1:0]         r_active;
    logic [FW-1:0]         r_pending;
    logic                  r_pending_valid;
    logic                  r_load_ready;
    logic [3:0]            r_bcd_out;
    logic [NUM_DIGITS-1:0] r_digit_sel;
    logic                  r_blank;
    logic                  r_frame_done;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                w_next_state;
    logic [IW-1:0]         w_next_index;
    logic [CW-1:0]         w_next_count;
    logic [FW-1:0]         w_next_active;
    logic [FW-1:0]         w_next_pending;
    logic                  w_next_pending_valid;
    logic                  w_next_frame_done;
    logic                  w_accept;

    logic [3:0]            w_bcd;
    logic [NUM_DIGITS-1:0] w_sel;
    logic                  w_blank;

    function automatic logic [3:0] nibble(input logic [FW-1:0] frame,
                                          input logic [IW-1:0] idx);
        logic [FW-1:0] shifted;
        shifted = frame >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

`ifdef LZ_SUPPRESS_EN
    // True when digit idx (idx > 0) and every digit above it are zero.
    function automatic logic leading_zero(input logic [FW-1:0] frame,
                                          input logic [IW-1:0] idx);
        logic [FW-1:0] shifted;
        shifted = frame >> {idx, 2'b00};
        return (idx != '0) && (shifted == '0);
    endfunction
`endif

    // Ready is only high while the pending buffer is empty. That keeps
    // acceptance and the pending-to-active copy from ever colliding.
    assign w_accept = load_valid && r_load_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state         = r_state;
        w_next_index         = r_index;
        w_next_count         = r_count;
        w_next_active        = r_active;
        w_next_pending       = r_pending;
        w_next_pending_valid = r_pending_valid;
        w_next_frame_done    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (r_pending_valid) begin
                    w_next_active        = r_pending;
                    w_next_pending_valid = 1'b0;
                end
                if (enable) begin
                    w_next_state = SLOT_START;
                    w_next_index = '0;
                    w_next_count = '0;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                    w_next_index = '0;
                    w_next_count = '0;
                end else if (r_count == BLANK_LAST) begin
                    w_next_state = ST_DRIVE;
                    w_next_count = '0;
                end else begin
                    w_next_count = r_count + CW'(1);
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    // Partial frame is abandoned; no frame_done.
                    w_next_state = ST_IDLE;
                    w_next_index = '0;
                    w_next_count = '0;
                end else if (r_count == SCAN_LAST) begin
                    w_next_state = SLOT_START;
                    w_next_count = '0;
                    if (r_index == IDX_LAST) begin
                        w_next_index      = '0;
                        w_next_frame_done = 1'b1;
                        // Frame boundary: a waiting frame becomes visible from digit 0.
                        if (r_pending_valid) begin
                            w_next_active        = r_pending;
                            w_next_pending_valid = 1'b0;
                        end
                    end else begin
                        w_next_index = r_index + IW'(1);
                    end
                end else begin
                    w_next_count = r_count + CW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_index = '0;
                w_next_count = '0;
            end
        endcase

        if (w_accept) begin
            w_next_pending       = load_data;
            w_next_pending_valid = 1'b1;
        end
    end

    // Outputs are derived from the next state so that, once registered, they
    // line up with the state they describe.
    always_comb begin
        w_bcd   = '0;
        w_sel   = '0;
        w_blank = 1'b1;
        unique case (w_next_state)
            ST_BLANK: begin
                // Present the nibble early so the decoder settles during dead-time.
                w_bcd = nibble(w_next_active, w_next_index);
            end
            ST_DRIVE: begin
                w_bcd   = nibble(w_next_active, w_next_index);
                w_sel   = NUM_DIGITS'(1) << w_next_index;
                w_blank = 1'b0;
`ifdef LZ_SUPPRESS_EN
                if (leading_zero(w_next_active, w_next_index)) begin
                    w_sel   = '0;
                    w_blank = 1'b1;
                end
`endif
            end
            default: begin
                w_bcd   = '0;
                w_sel   = '0;
                w_blank = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state         <= ST_IDLE;
            r_index         <= '0;
            r_count         <= '0;
            r_active        <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_load_ready    <= 1'b1;
            r_bcd_out       <= '0;
            r_digit_sel     <= '0;
            r_blank         <= 1'b1;
            r_frame_done    <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_index         <= w_next_index;
            r_count         <= w_next_count;
            r_active        <= w_next_active;
            r_pending       <= w_next_pending;
            r_pending_valid <= w_next_pending_valid;
            r_load_ready    <= !w_next_pending_valid;
            r_bcd_out       <= w_bcd;
            r_digit_sel     <= w_sel;
            r_blank         <= w_blank;
            r_frame_done    <= w_next_frame_done;
        end
    end

    assign load_ready = r_load_ready;
    assign bcd_out    = r_bcd_out;
    assign digit_sel  = r_digit_sel;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// tb_display_scan_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=2. The reference model tracks the scan as a cycle position
// within a 24-cycle frame; the digit and its phase come from division and
// remainder. Build with +define+LZ_SUPPRESS_EN to check the leading-zero
// variant.
// ============================================================================
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int B     = 2;
    localparam int SLOT  = B + S;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        load_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        blank;
    logic        frame_done;

    display_scan_ctrl #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .bcd_out   (bcd_out),
        .digit_sel (digit_sel),
        .blank     (blank),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit          m_run  = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_act  = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pv   = 1'b0;
    bit          m_fd   = 1'b0;
    bit          m_rst  = 1'b1;
    bit          m_acc  = 1'b0;
    logic [10:0] exp_vec;
    logic [10:0] exp_mask;
    logic [10:0] dut_vec;

    assign dut_vec = {load_ready, frame_done, blank, digit_sel, bcd_out};

    task automatic update_expect();
        int p;
        int d;
        int w;
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       blk;
        p = m_t % FRAME;
        d = p / SLOT;
        w = p % SLOT;
        sel = '0;
        bcd = '0;
        blk = 1'b1;
        exp_mask = '1;
        if (m_run) begin
            bcd = 4'((m_act >> (4 * d)) & 16'hF);
            if (w >= B) begin
                sel = 4'(1 << d);
                blk = 1'b0;
`ifdef LZ_SUPPRESS_EN
                if (d > 0 && (m_act >> (4 * d)) == 16'h0) begin
                    sel = '0;
                    blk = 1'b1;
                end
`endif
            end
        end else if (!m_rst) begin
            exp_mask[3:0] = '0;  // nibble while idle is not defined
        end
        exp_vec = {!m_pv, m_fd, blk, sel, bcd};
    endtask

    // Advance one clock: compute the model's next state from the inputs as
    // they stand, step the clock, then publish the expected outputs.
    task automatic tick();
        bit          n_run  = m_run;
        int          n_t    = m_t;
        logic [15:0] n_act  = m_act;
        logic [15:0] n_pend = m_pend;
        bit          n_pv   = m_pv;
        bit          n_fd   = 1'b0;
        bit          acc    = 1'b0;
        bit          rst    = reset;
        if (rst) begin
            n_run = 1'b0; n_t = 0; n_act = '0; n_pend = '0; n_pv = 1'b0;
        end else begin
            acc = load_valid && !m_pv;
            if (!m_run) begin
                if (m_pv) begin n_act = m_pend; n_pv = 1'b0; end
                if (enable) begin n_run = 1'b1; n_t = 0; end
            end else if (!enable) begin
                n_run = 1'b0;
            end else begin
                n_t = m_t + 1;
                if (n_t % FRAME == 0) begin
                    n_fd = 1'b1;
                    if (m_pv) begin n_act = m_pend; n_pv = 1'b0; end
                end
            end
            if (acc) begin n_pend = load_data; n_pv = 1'b1; end
        end
        @(posedge clk);
        #1;
        m_run = n_run; m_t = n_t; m_act = n_act; m_pend = n_pend;
        m_pv = n_pv; m_fd = n_fd; m_rst = rst; m_acc = acc;
        update_expect();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            reset      = 1'b1;
            enable     = 1'($urandom);
            load_valid = 1'($urandom);
            load_data  = 16'($urandom);
            tick();
            total++;
            if ({load_ready, digit_sel, blank, bcd_out, frame_done} !== {1'b1, 4'b0000, 1'b1, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL reset cycle %0d: got rdy=%b sel=%b blank=%b bcd=%h fd=%b, want rdy=1 sel=0000 blank=1 bcd=0 fd=0",
                         i, load_ready, digit_sel, blank, bcd_out, frame_done);
            end
        end
        reset = 1'b0; enable = 1'b0; load_valid = 1'b0;
    endtask

    task automatic test_scan();
        int pulses = 0;
        int first_at = -1;
        int last_at = -1;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        tick();
        load_valid = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 0; i <= 2 * FRAME; i++) begin
            tick();
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL scan t=%0d got=%03h want=%03h", m_t, dut_vec & exp_mask, exp_vec & exp_mask);
            end
            if (frame_done === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
                last_at = i;
            end
        end
        total++;
        if (pulses != 2 || last_at - first_at != FRAME) begin
            bad++;
            $display("FAIL scan_frame_done got pulses=%0d spacing=%0d want pulses=2 spacing=%0d",
                     pulses, last_at - first_at, FRAME);
        end
    endtask

    task automatic test_reload();
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 10; i++) tick();
        load_valid = 1'b1;
        load_data  = 16'h5678;
        tick();
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL reload_accept got rdy=%b want rdy=0", load_ready);
        end
        // Second offer held stable until the controller takes it.
        load_data = 16'($urandom);
        m_acc = 1'b0;
        for (int i = 0; i < 3 * FRAME && !m_acc; i++) begin
            tick();
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL reload_wait t=%0d got=%03h want=%03h", m_t, dut_vec & exp_mask, exp_vec & exp_mask);
            end
        end
        total++;
        if (!m_acc) begin
            bad++;
            $display("FAIL reload_second_accept got none within %0d cycles want one", 3 * FRAME);
        end
        load_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            tick();
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL reload_run t=%0d got=%03h want=%03h", m_t, dut_vec & exp_mask, exp_vec & exp_mask);
            end
        end
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 14; i++) tick();
        enable = 1'b0;
        tick();
        total++;
        if ({digit_sel, blank, frame_done} !== {4'b0000, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL enable_drop got sel=%b blank=%b fd=%b want sel=0000 blank=1 fd=0",
                     digit_sel, blank, frame_done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL enable_idle got=%03h want=%03h", dut_vec & exp_mask, exp_vec & exp_mask);
            end
        end
        enable = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            tick();
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL enable_restart t=%0d got=%03h want=%03h", m_t, dut_vec & exp_mask, exp_vec & exp_mask);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 8; i++) tick();
        load_valid = 1'b1;
        load_data  = 16'($urandom) | 16'h1111;
        tick();
        load_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        total++;
        if ({load_ready, digit_sel, blank, bcd_out, frame_done} !== {1'b1, 4'b0000, 1'b1, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid got rdy=%b sel=%b blank=%b bcd=%h fd=%b want rdy=1 sel=0000 blank=1 bcd=0 fd=0",
                     load_ready, digit_sel, blank, bcd_out, frame_done);
        end
        reset = 1'b0;
        for (int i = 0; i <= FRAME; i++) begin
            tick();
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL reset_mid_run t=%0d got=%03h want=%03h", m_t, dut_vec & exp_mask, exp_vec & exp_mask);
            end
        end
    endtask

    task automatic test_leading_zero();
        int driven = 0;
        int want_driven;
`ifdef LZ_SUPPRESS_EN
        want_driven = 2 * S;
`else
        want_driven = N * S;
`endif
        enable = 1'b0;
        tick();
        load_valid = 1'b1;
        load_data  = 16'h0070;
        tick();
        load_valid = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            tick();
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL lz t=%0d got=%03h want=%03h", m_t, dut_vec & exp_mask, exp_vec & exp_mask);
            end
            if (i < FRAME && blank === 1'b0) driven++;
        end
        total++;
        if (driven != want_driven) begin
            bad++;
            $display("FAIL lz_driven_cycles got=%0d want=%0d", driven, want_driven);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 39) != 0);
            if (!load_valid && $urandom_range(0, 19) == 0) begin
                load_valid = 1'b1;
                load_data  = 16'($urandom);
            end
            tick();
            if (m_acc || m_rst) load_valid = 1'b0;
            total++;
            if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
                bad++;
                $display("FAIL random i=%0d got=%03h want=%03h", i, dut_vec & exp_mask, exp_vec & exp_mask);
            end
        end
        reset = 1'b0;
        load_valid = 1'b0;
    endtask

    initial begin
        update_expect();
        test_reset();
        test_scan();
        test_reload();
        test_enable_drop();
        test_reset_mid();
        test_leading_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
